id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage of the RISC-V core. It registers the decoded control bundle from the control unit (branch, memRead, memtoReg, ALUOp, memWrite, ALUSrc, regWrite) together with the operands and register indices. It detects load-use hazards against the instruction currently in EX, and inserts bubbles on hazard or branch flush. It also holds its contents when the downstream stage stalls.

## Interface
- XLEN, 32, datapath width for pc, rs1/rs2 data and immediate.
- CNT_W, 16, width of saturating bubble counter.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID slot holds a real instruction
- id_opcode  in  7  opcode of ID instruction (for operand-use decode)
- id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc, id_regWrite  in  1 each  control from control unit
- id_ALUOp  in  2  ALU operation class from control unit
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  ID operands
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct3  in  3; id_funct7_5  in  1  ALU control fields
- hold_i  in  1  EX/MEM cannot accept; freeze this stage
- flush_i  in  1  branch/JAL taken in EX; kill the ID instruction
- ex_* (valid, every control bit, ALUOp, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, funct7_5)  out  matching widths  registered EX bundle
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_cnt  out  CNT_W  count of inserted bubbles, saturating

## Operation
- Hazard: `haz = ex_valid & ex_memRead & (ex_rd != 0) & ((use_rs1 & ex_rd == id_rs1) | (use_rs2 & ex_rd == id_rs2))`.
  - use_rs1 is 1 except for JAL (1101111).
  - use_rs2 is 1 for R-type (0110011), SW (0100011) and branch (1100011).
- `stall_o = id_valid & haz & ~flush_i & ~pend_flush`.
- Per-edge update, in priority order:
  - hold_i=1: all ex_* keep their value. If flush_i=1, set pend_flush.
  - else if flush_i | pend_flush: load bubble, clear pend_flush, increment bubble_cnt.
  - else if stall_o: load bubble, increment bubble_cnt.
  - else: load the id_* bundle. ex_valid takes id_valid. If id_valid=0, the control bits load as 0.
- Bubble: ex_valid=0, all control bits 0, ALUOp=00, all data and index fields 0.
- bubble_cnt stops at 2^CNT_W-1 and does not wrap.

## Timing
- Reset (async assert, sync release on clk): every ex_* output 0, pend_flush 0, bubble_cnt 0.
  - stall_o therefore reads 0 out of reset.
- Latency: 1 cycle, ID to EX.
- stall_o is valid in the same cycle as the ID inputs. Upstream must hold the ID inputs stable while stall_o=1.
- A load-use pair costs exactly one bubble. The next cycle the load is in MEM, haz=0, and the consumer enters EX.
- flush_i together with a hazard: the flush bubble is inserted and stall_o=0, because the killed instruction must not stall the front end.
- flush_i during hold_i: the flush is remembered in pend_flush and applied on the first cycle with hold_i=0.
- hold_i together with stall_o: stall_o stays asserted. Nothing changes in this stage.
- Reset mid-stall: outputs clear immediately and stall_o drops combinationally.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_BRANCH, OPC_JAL, OPC_ITYPE.
  - ALUOp encodings ALUOP_ADD=00, ALUOP_BR=01, ALUOP_R=10, ALUOP_I=11.
  - XLEN default.
  - packed struct `ctrl_t` holding the seven control fields.
- One sub-module, `hazard_detect`: combinational; inputs are ex_valid, ex_memRead, ex_rd, id_opcode, id_rs1, id_rs2; output is haz.
- All registers live in id_ex_stage.

## Test plan
- **Reset:** rst_n=0 mid-traffic → all ex_* = 0, stall_o=0, bubble_cnt=0, asynchronously, before the next clk edge.
- **Plain pass-through:** ADD x3,x1,x2 (regWrite=1, ALUOp=10, rd=3) → ex_regWrite=1, ex_ALUOp=10, ex_rd=3 one cycle later; stall_o=0.
- **Load-use:** LW x5 then ADD x6,x5,x1 → stall_o=1 for one cycle, one bubble with ex_valid=0, then the ADD enters EX; bubble_cnt=1.
- **No false hazards:**
  - LW x0 then ADD x6,x0,x1 → stall_o=0.
  - LW x5 then JAL x1 with rs1 field=5 → stall_o=0.
- **Flush beats hazard:** LW x5 in EX, dependent ADD in ID, flush_i=1 → stall_o=0, bubble inserted, bubble_cnt increments by 1.
- **Flush under hold:** hold_i=1 and flush_i=1 for 2 cycles → ex_* frozen. When hold_i=0 with flush_i=0, the next edge loads a bubble and pend_flush clears.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, ALUOp classes, control bundle.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   typedef struct packed {
      logic       branch;
      logic       memRead;
      logic       memtoReg;
      logic [1:0] ALUOp;
      logic       memWrite;
      logic       ALUSrc;
      logic       regWrite;
   } ctrl_t;

   // JAL has no rs1 operand; everything else reads rs1 (or ignores a harmless match).
   function automatic logic uses_rs1(input logic [6:0] opc);
      return opc != OPC_JAL;
   endfunction

   // Only R-type, stores and branches read rs2.
   function automatic logic uses_rs2(input logic [6:0] opc);
      return (opc == OPC_RTYPE) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check of the ID instruction against the load in EX.
module hazard_detect
   import riscv_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_memRead,
   input  logic [4:0] ex_rd,
   input  logic [6:0] id_opcode,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       haz
);

   logic rs1_hit, rs2_hit;

   // x0 never carries a dependency, so a load to x0 cannot stall.
   always_comb begin
      rs1_hit = uses_rs1(id_opcode) && (ex_rd == id_rs1);
      rs2_hit = uses_rs2(id_opcode) && (ex_rd == id_rs2);
      haz     = ex_valid && ex_memRead && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and downstream hold.
module id_ex_stage #(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [6:0]      id_opcode,
   input  logic            id_branch,
   input  logic            id_memRead,
   input  logic            id_memtoReg,
   input  logic [1:0]      id_ALUOp,
   input  logic            id_memWrite,
   input  logic            id_ALUSrc,
   input  logic            id_regWrite,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7_5,
   input  logic            hold_i,
   input  logic            flush_i,
   output logic            ex_valid,
   output logic            ex_branch,
   output logic            ex_memRead,
   output logic            ex_memtoReg,
   output logic [1:0]      ex_ALUOp,
   output logic            ex_memWrite,
   output logic            ex_ALUSrc,
   output logic            ex_regWrite,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7_5,
   output logic            stall_o,
   output logic [CNT_W-1:0] bubble_cnt
);

   import riscv_pkg::*;

   typedef struct packed {
      logic            valid;
      ctrl_t           ctrl;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            funct7_5;
   } ex_t;

   ex_t             ex_d, ex_q, id_bun;
   logic            pend_flush_d, pend_flush_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic            ins_bubble;
   logic            haz;

   hazard_detect u_haz (
      .ex_valid   (ex_q.valid),
      .ex_memRead (ex_q.ctrl.memRead),
      .ex_rd      (ex_q.rd),
      .id_opcode  (id_opcode),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .haz        (haz)
   );

   // A killed (or already-killed) ID instruction must not freeze the front end.
   assign stall_o = id_valid & haz & ~flush_i & ~pend_flush_q;

   // Gather the ID bundle; an empty slot carries no control so it cannot act in EX.
   always_comb begin
      id_bun          = '0;
      id_bun.valid    = id_valid;
      if (id_valid) begin
         id_bun.ctrl.branch   = id_branch;
         id_bun.ctrl.memRead  = id_memRead;
         id_bun.ctrl.memtoReg = id_memtoReg;
         id_bun.ctrl.ALUOp    = id_ALUOp;
         id_bun.ctrl.memWrite = id_memWrite;
         id_bun.ctrl.ALUSrc   = id_ALUSrc;
         id_bun.ctrl.regWrite = id_regWrite;
      end
      id_bun.pc       = id_pc;
      id_bun.rs1_data = id_rs1_data;
      id_bun.rs2_data = id_rs2_data;
      id_bun.imm      = id_imm;
      id_bun.rs1      = id_rs1;
      id_bun.rs2      = id_rs2;
      id_bun.rd       = id_rd;
      id_bun.funct3   = id_funct3;
      id_bun.funct7_5 = id_funct7_5;
   end

   // Next-state: hold > flush (live or pending) > stall bubble > normal load.
   always_comb begin
      ex_d         = ex_q;
      pend_flush_d = pend_flush_q;
      cnt_d        = cnt_q;
      ins_bubble   = 1'b0;
      if (hold_i) begin
         if (flush_i) pend_flush_d = 1'b1;
      end else if (flush_i || pend_flush_q) begin
         ex_d         = '0;
         pend_flush_d = 1'b0;
         ins_bubble   = 1'b1;
      end else if (stall_o) begin
         ex_d       = '0;
         ins_bubble = 1'b1;
      end else begin
         ex_d = id_bun;
      end
      if (ins_bubble && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
   end

   // Stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q         <= '0;
         pend_flush_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         ex_q         <= ex_d;
         pend_flush_q <= pend_flush_d;
         cnt_q        <= cnt_d;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_branch   = ex_q.ctrl.branch;
   assign ex_memRead  = ex_q.ctrl.memRead;
   assign ex_memtoReg = ex_q.ctrl.memtoReg;
   assign ex_ALUOp    = ex_q.ctrl.ALUOp;
   assign ex_memWrite = ex_q.ctrl.memWrite;
   assign ex_ALUSrc   = ex_q.ctrl.ALUSrc;
   assign ex_regWrite = ex_q.ctrl.regWrite;
   assign ex_pc       = ex_q.pc;
   assign ex_rs1_data = ex_q.rs1_data;
   assign ex_rs2_data = ex_q.rs2_data;
   assign ex_imm      = ex_q.imm;
   assign ex_rs1      = ex_q.rs1;
   assign ex_rs2      = ex_q.rs2;
   assign ex_rd       = ex_q.rd;
   assign ex_funct3   = ex_q.funct3;
   assign ex_funct7_5 = ex_q.funct7_5;
   assign bubble_cnt  = cnt_q;

endmodule
